// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback over a shared req/ready memory port with a wait watchdog.
module multicycle_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam bit         WATCHDOG_ON = (TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t     cur_state;
  state_t     next_state;
  logic [7:0] wait_cnt;

  // Raw Moore/handshake strobes before reset gating
  logic req_m;
  logic memwrite_m;
  logic irwrite_m;
  logic pcwrite_m;
  logic regwrite_m;
  logic set_illegal;
  logic timeout_hit;
  logic take;
  logic bad_f3;

  always_comb begin
    take   = 1'b0;
    bad_f3 = 1'b0;
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    next_state  = cur_state;
    req_m       = 1'b0;
    memwrite_m  = 1'b0;
    AdrSrc      = 1'b0;
    irwrite_m   = 1'b0;
    pcwrite_m   = 1'b0;
    regwrite_m  = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    set_illegal = 1'b0;
    timeout_hit = 1'b0;

    case (cur_state)
      S_FETCH: begin
        req_m     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_m = mem_ready;
        pcwrite_m = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI, OP_AUIPC:  next_state = S_UPPER;
          default: begin
            next_state  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_m  = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_m = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        req_m      = 1'b1;
        memwrite_m = 1'b1;
        AdrSrc     = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_m = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        if (bad_f3) begin
          next_state  = S_TRAP;
          set_illegal = 1'b1;
        end else begin
          pcwrite_m  = take;
          next_state = S_FETCH;
        end
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = S_JAL;
      end
      S_JAL: begin
        pcwrite_m  = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        next_state = S_ALUWB;
      end
      S_UPPER: begin
        ALUSrcA    = op[5] ? 2'b11 : 2'b01;
        ALUSrcB    = 2'b01;
        next_state = S_ALUWB;
      end
      default: next_state = S_TRAP;
    endcase

    // Expiry only applies while still unanswered; a same-cycle mem_ready completes normally
    if (WATCHDOG_ON && req_m && !mem_ready && (wait_cnt == TIMEOUT_CNT)) begin
      timeout_hit = 1'b1;
      next_state  = S_TRAP;
      irwrite_m   = 1'b0;
      pcwrite_m   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_FETCH;
      wait_cnt  <= 8'd0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (!req_m || mem_ready) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (set_illegal) illegal <= 1'b1;
      if (timeout_hit) bus_err <= 1'b1;
    end
  end

  // Reset is asynchronous, so strobes are gated directly to drop the bus mid-access
  assign mem_req  = req_m & reset;
  assign MemWrite = memwrite_m & reset;
  assign IRWrite  = irwrite_m & reset;
  assign PCWrite  = pcwrite_m & reset;
  assign RegWrite = regwrite_m & reset;
  assign state    = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// tb_multicycle_controller: directed instruction sequences with an expected-output scoreboard.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, lt, ltu;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal, bus_err;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  logic [19:0] sb[$];
  logic exp_ill = 1'b0;
  logic exp_be  = 1'b0;

  multicycle_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .Zero(Zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, bus_err}
  function automatic logic [19:0] pk(input logic [3:0] st, input logic req, mw, adr, irw, pcw, rw,
                                     input logic [1:0] rs, sa, sbv, aop);
    return {st, req, mw, adr, irw, pcw, rw, rs, sa, sbv, aop, exp_ill, exp_be};
  endfunction

  function automatic logic [19:0] e_fetch(input logic rdy);
    return pk(4'd0, 1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, 2'b00);
  endfunction
  function automatic logic [19:0] e_decode();   return pk(4'd1, 0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00); endfunction
  function automatic logic [19:0] e_memadr();   return pk(4'd2, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00); endfunction
  function automatic logic [19:0] e_memread();  return pk(4'd3, 1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] e_memwb();    return pk(4'd4, 0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] e_memwrite(); return pk(4'd5, 1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] e_execr();    return pk(4'd6, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10); endfunction
  function automatic logic [19:0] e_aluwb();    return pk(4'd7, 0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] e_execi();    return pk(4'd8, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10); endfunction
  function automatic logic [19:0] e_jal();      return pk(4'd9, 0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 2'b00); endfunction
  function automatic logic [19:0] e_branch(input logic tk);
    return pk(4'd10, 0,0,0,0,tk,0, 2'b00, 2'b10, 2'b00, 2'b01);
  endfunction
  function automatic logic [19:0] e_jalr();     return pk(4'd11, 0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00); endfunction
  function automatic logic [19:0] e_upper(input logic [1:0] sa);
    return pk(4'd12, 0,0,0,0,0,0, 2'b00, sa, 2'b01, 2'b00);
  endfunction
  function automatic logic [19:0] e_trap();     return pk(4'd13, 0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00); endfunction
  function automatic logic [19:0] e_rst();      return pk(4'd0, 0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00); endfunction

  task automatic compare(input string tag);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal, bus_err};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Drive inputs just after a falling edge, sample 1ns later, then advance one cycle
  task automatic step(input string tag, input logic rdy, input logic [19:0] e);
    mem_ready = rdy;
    sb.push_back(e);
    #1;
    compare(tag);
    @(negedge clk);
  endtask

  task automatic chk_imm(input string tag, input logic [2:0] e);
    checks++;
    assert (ImmSrc === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, ImmSrc, e);
    end
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b0;
    exp_ill = 1'b0;
    exp_be  = 1'b0;
    sb.push_back(e_rst());
    #1;
    compare(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic z, l, lu);
    op = o; funct3 = f3; Zero = z; lt = l; ltu = lu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0;
    mem_ready = 1'b0;
    set_instr(7'b0, 3'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    do_reset("reset_init");

    // R-type add
    set_instr(7'b0110011, 3'b000, 0, 0, 0);
    step("add_fetch", 1, e_fetch(1));
    step("add_decode", 1, e_decode());
    step("add_execr", 1, e_execr());
    step("add_aluwb", 1, e_aluwb());

    // lw with three wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 0, 0, 0);
    step("lw_fetch", 1, e_fetch(1));
    chk_imm("lw_imm", 3'b000);
    step("lw_decode", 1, e_decode());
    step("lw_memadr", 1, e_memadr());
    for (int i = 0; i < 3; i++) step("lw_memread_wait", 0, e_memread());
    step("lw_memread_done", 1, e_memread());
    step("lw_memwb", 1, e_memwb());

    // sw with mem_ready arriving on the expiry cycle
    set_instr(7'b0100011, 3'b010, 0, 0, 0);
    step("sw_fetch", 1, e_fetch(1));
    chk_imm("sw_imm", 3'b001);
    step("sw_decode", 1, e_decode());
    step("sw_memadr", 1, e_memadr());
    for (int i = 0; i < 4; i++) step("sw_memwrite_wait", 0, e_memwrite());
    step("sw_memwrite_edge", 1, e_memwrite());

    // Branches
    set_instr(7'b1100011, 3'b000, 1, 0, 0);
    step("beq_fetch", 1, e_fetch(1));
    chk_imm("beq_imm", 3'b010);
    step("beq_decode", 1, e_decode());
    step("beq_taken", 1, e_branch(1));
    set_instr(7'b1100011, 3'b001, 1, 0, 0);
    step("bne_fetch", 1, e_fetch(1));
    step("bne_decode", 1, e_decode());
    step("bne_not_taken", 1, e_branch(0));
    set_instr(7'b1100011, 3'b100, 0, 1, 0);
    step("blt_fetch", 1, e_fetch(1));
    step("blt_decode", 1, e_decode());
    step("blt_taken", 1, e_branch(1));
    set_instr(7'b1100011, 3'b111, 0, 0, 1);
    step("bgeu_fetch", 1, e_fetch(1));
    step("bgeu_decode", 1, e_decode());
    step("bgeu_not_taken", 1, e_branch(0));

    // jalr / jal / lui / auipc / addi
    set_instr(7'b1100111, 3'b000, 0, 0, 0);
    step("jalr_fetch", 1, e_fetch(1));
    step("jalr_decode", 1, e_decode());
    step("jalr_jalr", 1, e_jalr());
    step("jalr_jal", 1, e_jal());
    step("jalr_aluwb", 1, e_aluwb());
    set_instr(7'b1101111, 3'b000, 0, 0, 0);
    step("jal_fetch", 1, e_fetch(1));
    chk_imm("jal_imm", 3'b011);
    step("jal_decode", 1, e_decode());
    step("jal_jal", 1, e_jal());
    step("jal_aluwb", 1, e_aluwb());
    set_instr(7'b0110111, 3'b000, 0, 0, 0);
    step("lui_fetch", 1, e_fetch(1));
    chk_imm("lui_imm", 3'b100);
    step("lui_decode", 1, e_decode());
    step("lui_upper", 1, e_upper(2'b11));
    step("lui_aluwb", 1, e_aluwb());
    set_instr(7'b0010111, 3'b000, 0, 0, 0);
    step("auipc_fetch", 1, e_fetch(1));
    step("auipc_decode", 1, e_decode());
    step("auipc_upper", 1, e_upper(2'b01));
    step("auipc_aluwb", 1, e_aluwb());
    set_instr(7'b0010011, 3'b000, 0, 0, 0);
    step("addi_fetch", 1, e_fetch(1));
    step("addi_decode", 1, e_decode());
    step("addi_execi", 1, e_execi());
    step("addi_aluwb", 1, e_aluwb());

    // Unsupported branch funct3 traps without PCWrite
    set_instr(7'b1100011, 3'b010, 1, 1, 1);
    step("bf3_fetch", 1, e_fetch(1));
    step("bf3_decode", 1, e_decode());
    step("bf3_branch", 1, e_branch(0));
    exp_ill = 1'b1;
    step("bf3_trap", 1, e_trap());
    do_reset("reset_after_bf3");

    // Illegal opcode, trap held, then reset mid-trap
    set_instr(7'b1111111, 3'b000, 0, 0, 0);
    step("ill_fetch", 1, e_fetch(1));
    step("ill_decode", 1, e_decode());
    exp_ill = 1'b1;
    step("ill_trap0", 1, e_trap());
    step("ill_trap1", 1, e_trap());
    step("ill_trap2", 0, e_trap());
    do_reset("reset_mid_trap");

    // Watchdog expiry in FETCH
    set_instr(7'b0110011, 3'b000, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("to_fetch_wait", 0, e_fetch(0));
    exp_be = 1'b1;
    step("to_trap0", 0, e_trap());
    step("to_trap1", 1, e_trap());
    do_reset("reset_after_timeout");

    // Asynchronous reset drops an in-flight store
    set_instr(7'b0100011, 3'b010, 0, 0, 0);
    step("sw2_fetch", 1, e_fetch(1));
    step("sw2_decode", 1, e_decode());
    step("sw2_memadr", 1, e_memadr());
    step("sw2_memwrite", 0, e_memwrite());
    do_reset("reset_mid_access");
    step("post_reset_fetch", 1, e_fetch(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
